fetch_decode_packetizer: RTL and testbench
==========================================

Name: fetch_decode_packetizer

Overview:
- Sits between the fetch stage and the RISC-V decode lanes; it is the producer side of the decPkt interface.
- Buffers fetched instruction bundles and slices them into per-lane decPkts.
- Assigns sequence numbers (seqNo) and control-transfer IDs (ctiID), pre-decodes ctrlType, and converts fetch faults into exception packets.
- Applies downstream stall and flush/recovery.

Parameters:
- FETCH_WIDTH, 4, instruction slots per fetch bundle.
- DEC_WIDTH, 2, decPkts emitted per cycle; DEC_WIDTH <= FETCH_WIDTH.
- DEPTH, 2, bundle FIFO entries.
- SIZE_SEQ, 8, seqNo width; wraps modulo 2^SIZE_SEQ.
- SIZE_CTI, 4, ctiID width; wraps modulo 2^SIZE_CTI.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush_i  in  1  pipeline recovery; discards buffered and incoming bundles.
- recoverCtiID_i  in  SIZE_CTI  ctiID to resume from after flush.
- fetchValid_i  in  1  fetch bundle present.
- fetchReady_o  out  1  bundle accepted this cycle when valid&&ready.
- fetchPC_i  in  SIZE_PC  PC of slot 0; slot k PC = fetchPC_i + 4k.
- fetchInst_i  in  FETCH_WIDTH*32  instructions, slot 0 in LSBs.
- fetchMask_i  in  FETCH_WIDTH  per-slot valid.
- fetchPredNPC_i  in  FETCH_WIDTH*SIZE_PC  per-slot predicted next PC.
- fetchPredDir_i  in  FETCH_WIDTH  per-slot predicted direction.
- fetchExc_i  in  1  fetch fault for the whole bundle.
- fetchExcCause_i  in  EXCEPTION_CAUSE_LOG  fault cause.
- stall_i  in  1  downstream cannot accept packets this cycle.
- decPacket_o  out  DEC_WIDTH x decPkt  lane packets; .valid per lane.

Behaviour:
- Reset, asynchronous: FIFO empty, slot pointer 0, seqNo 0, ctiID 0, fetchReady_o=1, all decPacket_o[*].valid=0.
- Enqueue:
  - fetchReady_o = (count < DEPTH); no same-cycle bypass.
  - Accepted bundle is visible on decPacket_o no earlier than the next cycle.
  - A bundle with fetchMask_i==0 and fetchExc_i==0 is accepted and discarded; it is not stored.
- Emission, combinational from the head entry, slot pointer and counters:
  - Lanes 0..DEC_WIDTH-1 take the next valid slots at or after the pointer, in slot order, skipping masked slots.
  - Unfilled lanes have valid=0.
  - Outputs must be stable while stall_i=1.
- Advance, when stall_i=0 and at least one lane is valid:
  - Pointer moves past the last emitted slot.
  - If no valid slots remain in the head entry, pop it and reset the pointer to 0; this can happen in the same cycle as an enqueue.
- seqNo: lane i carries seqNo_reg + i (valid lanes are contiguous from lane 0). seqNo_reg advances by the number of valid lanes on advance, with wrap.
- ctrlType pre-decode from opcode:
  - JAL -> direct jump; JALR -> indirect jump (return when rd=x0 and rs1=x1); BRANCH -> conditional branch; otherwise none.
  - Use the ctrlType encodings from the shared package.
- ctiID: each control lane gets ctiID_reg plus the count of control lanes before it in the same cycle. ctiID_reg advances by the number of control lanes on advance.
- predNPC/predDir are copied from the slot. Non-control slots get predNPC = PC+4 and predDir=0.
- Exception bundle:
  - Emits exactly one packet on lane 0: pc = PC of the first valid slot (fetchPC_i if mask==0), inst = 32'h00000013, exception=1, exceptionCause = stored cause, ctrlType none.
  - Other lanes are invalid; the bundle is popped on advance.
- Flush:
  - Next edge: FIFO empty, pointer 0, ctiID_reg = recoverCtiID_i. seqNo_reg is not rewound.
  - Outputs are invalid in the flush cycle.
  - flush_i with fetchValid_i in the same cycle: the incoming bundle is dropped and fetchReady_o is ignored.
  - flush_i has priority over stall_i.
- Reset asserted mid-bundle: state clears immediately; the partially emitted bundle is lost.

Decomposition:
- Shared package additions: ctrlType encodings, the NOP constant, a fetchBundle struct (pc, inst[], mask, predNPC[], predDir, exc, cause). The existing decPkt and EXCEPTION_CAUSE_LOG are reused.
- One sub-module, fetch_bundle_fifo: a DEPTH-entry register FIFO with count, push/pop and flush.
- Slot selection, counters and pre-decode live in the top module.

Test Plan:
- Reset then a full bundle: mask 4'b1111 at PC 0x1000, stall_i=0 -> cycle 1 lanes PC 0x1000/0x1004 with seq 0/1; cycle 2 PC 0x1008/0x100C with seq 2/3; entry popped.
- Sparse mask 4'b1010 -> one cycle with lane0 PC+4 and lane1 PC+12; seq advances by 2.
- BRANCH in slot 1 and JAL in slot 2 with ctiID_reg=15 (SIZE_CTI=4) -> ctiIDs 15 then 0; ctiID_reg=1 afterward.
- stall_i held 3 cycles mid-bundle -> decPacket_o unchanged for those cycles; FIFO fills to 2 and fetchReady_o=0; emission resumes in order with no seqNo gaps.
- fetchExc_i=1 with cause 1 and mask 4'b0110 -> a single lane0 packet with exception=1, cause 1, pc=PC+4, inst 0x00000013; the next bundle follows on the next cycle.
- flush_i with fetchValid_i=1 and recoverCtiID_i=5 while 2 bundles are buffered -> next cycle outputs invalid, fetchReady_o=1; the next packet's seqNo continues from the pre-flush value; the first control lane gets ctiID 5.

Source files
------------

// File: rtl/fetch_decode_packetizer_pkg.sv
// Shared types for the fetch-to-decode boundary: decode packet, fetch bundle,
// control-transfer classes and the opcode pre-decode helper.
package fetch_decode_packetizer_pkg;

    localparam int FETCH_WIDTH         = 4;
    localparam int DEC_WIDTH           = 2;
    localparam int DEPTH               = 2;
    localparam int SIZE_SEQ            = 8;
    localparam int SIZE_CTI            = 4;
    localparam int SIZE_PC             = 32;
    localparam int EXCEPTION_CAUSE_LOG = 4;
    localparam int SLOT_W              = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        CTRL_NONE          = 3'd0,
        CTRL_JUMP_DIRECT   = 3'd1,
        CTRL_JUMP_INDIRECT = 3'd2,
        CTRL_RETURN        = 3'd3,
        CTRL_BRANCH        = 3'd4
    } ctrlType_t;

    typedef struct packed {
        logic                           valid;
        logic [SIZE_PC-1:0]             pc;
        logic [31:0]                    inst;
        logic [SIZE_SEQ-1:0]            seqNo;
        logic [SIZE_CTI-1:0]            ctiID;
        ctrlType_t                      ctrlType;
        logic [SIZE_PC-1:0]             predNPC;
        logic                           predDir;
        logic                           exception;
        logic [EXCEPTION_CAUSE_LOG-1:0] exceptionCause;
    } decPkt;

    typedef struct packed {
        logic [SIZE_PC-1:0]                      pc;
        logic [FETCH_WIDTH-1:0][31:0]            inst;
        logic [FETCH_WIDTH-1:0]                  mask;
        logic [FETCH_WIDTH-1:0][SIZE_PC-1:0]     predNPC;
        logic [FETCH_WIDTH-1:0]                  predDir;
        logic                                    exc;
        logic [EXCEPTION_CAUSE_LOG-1:0]          cause;
    } fetchBundle;

    // jalr x0, 0(x1) is the canonical return
    function automatic ctrlType_t preDecode(input logic [31:0] inst);
        ctrlType_t t;
        t = CTRL_NONE;
        case (inst[6:0])
            OPC_JAL:    t = CTRL_JUMP_DIRECT;
            OPC_JALR:   t = (inst[11:7] == 5'd0 && inst[19:15] == 5'd1) ? CTRL_RETURN
                                                                       : CTRL_JUMP_INDIRECT;
            OPC_BRANCH: t = CTRL_BRANCH;
            default:    t = CTRL_NONE;
        endcase
        return t;
    endfunction

    function automatic logic [SLOT_W-1:0] lowestSlot(input logic [FETCH_WIDTH-1:0] m);
        logic [SLOT_W-1:0] r;
        r = '0;
        for (int s = FETCH_WIDTH - 1; s >= 0; s--) begin
            if (m[s]) r = SLOT_W'(s);
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_bundle_fifo.sv
// Small register FIFO holding whole fetch bundles between fetch and slicing.
module fetch_bundle_fifo
    import fetch_decode_packetizer_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetchBundle                   pushData,
    input  logic                         pop,
    output fetchBundle                   headData,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetchBundle         mem [DEPTH];
    logic [PTR_W-1:0]   headPtr;
    logic [PTR_W-1:0]   tailPtr;
    logic [CNT_W-1:0]   countReg;

    function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[tailPtr] <= pushData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            countReg <= '0;
        end else if (flush) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            countReg <= '0;
        end else begin
            if (push) tailPtr <= incPtr(tailPtr);
            if (pop)  headPtr <= incPtr(headPtr);
            countReg <= countReg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign headData = mem[headPtr];
    assign count    = countReg;
    assign empty    = (countReg == '0);

endmodule

// File: rtl/fetch_decode_packetizer.sv
// Slices buffered fetch bundles into per-lane decode packets, numbering them
// and tagging control transfers; fetch faults become single exception packets.
module fetch_decode_packetizer
    import fetch_decode_packetizer_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush_i,
    input  logic [SIZE_CTI-1:0]              recoverCtiID_i,
    input  logic                             fetchValid_i,
    output logic                             fetchReady_o,
    input  logic [SIZE_PC-1:0]               fetchPC_i,
    input  logic [FETCH_WIDTH*32-1:0]        fetchInst_i,
    input  logic [FETCH_WIDTH-1:0]           fetchMask_i,
    input  logic [FETCH_WIDTH*SIZE_PC-1:0]   fetchPredNPC_i,
    input  logic [FETCH_WIDTH-1:0]           fetchPredDir_i,
    input  logic                             fetchExc_i,
    input  logic [EXCEPTION_CAUSE_LOG-1:0]   fetchExcCause_i,
    input  logic                             stall_i,
    output decPkt [DEC_WIDTH-1:0]            decPacket_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetchBundle             inBundle;
    fetchBundle             headBundle;
    logic                   push;
    logic                   pop;
    logic                   fifoEmpty;
    logic [CNT_W-1:0]       fifoCount;

    logic [SLOT_W-1:0]      slotPtr;
    logic [SLOT_W-1:0]      slotPtrNext;
    logic [SIZE_SEQ-1:0]    seqNoReg;
    logic [SIZE_CTI-1:0]    ctiIDReg;
    logic                   advance;
    logic                   outEn;

    logic [FETCH_WIDTH-1:0] avail;
    logic [FETCH_WIDTH-1:0] leftMask;
    logic [SIZE_SEQ-1:0]    laneCnt;
    logic [SIZE_CTI-1:0]    ctrlCnt;
    logic [SLOT_W-1:0]      laneSlot;
    logic [SIZE_PC-1:0]     lanePc;
    logic [31:0]            laneInst;
    ctrlType_t              laneCtrl;
    logic                   laneValid;

    assign inBundle.pc      = fetchPC_i;
    assign inBundle.inst    = fetchInst_i;
    assign inBundle.mask    = fetchMask_i;
    assign inBundle.predNPC = fetchPredNPC_i;
    assign inBundle.predDir = fetchPredDir_i;
    assign inBundle.exc     = fetchExc_i;
    assign inBundle.cause   = fetchExcCause_i;

    assign fetchReady_o = (fifoCount < CNT_W'(DEPTH));

    // Empty, fault-free bundles are acknowledged but never stored
    assign push = fetchValid_i && fetchReady_o && !flush_i && ((|fetchMask_i) || fetchExc_i);

    fetch_bundle_fifo u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush_i),
        .push     (push),
        .pushData (inBundle),
        .pop      (pop),
        .headData (headBundle),
        .count    (fifoCount),
        .empty    (fifoEmpty)
    );

    always_comb begin
        decPacket_o = '0;
        avail       = '0;
        leftMask    = '0;
        slotPtrNext = '0;
        laneCnt     = '0;
        ctrlCnt     = '0;
        laneSlot    = '0;
        lanePc      = '0;
        laneInst    = '0;
        laneCtrl    = CTRL_NONE;
        laneValid   = 1'b0;
        outEn       = !fifoEmpty && !flush_i;

        for (int s = 0; s < FETCH_WIDTH; s++) begin
            avail[s] = headBundle.mask[s] && (s >= int'(slotPtr));
        end

        if (outEn && headBundle.exc) begin
            lanePc = headBundle.pc + SIZE_PC'({lowestSlot(headBundle.mask), 2'b00});
            decPacket_o[0].valid          = 1'b1;
            decPacket_o[0].pc             = lanePc;
            decPacket_o[0].inst           = NOP_INST;
            decPacket_o[0].seqNo          = seqNoReg;
            decPacket_o[0].ctiID          = ctiIDReg;
            decPacket_o[0].ctrlType       = CTRL_NONE;
            decPacket_o[0].predNPC        = lanePc + SIZE_PC'(4);
            decPacket_o[0].predDir        = 1'b0;
            decPacket_o[0].exception      = 1'b1;
            decPacket_o[0].exceptionCause = headBundle.cause;
            laneCnt = SIZE_SEQ'(1);
        end else begin
            // Each lane takes the lowest remaining valid slot, then clears it
            for (int i = 0; i < DEC_WIDTH; i++) begin
                laneValid = outEn && (avail != '0);
                laneSlot  = lowestSlot(avail);
                avail     = avail & (avail - FETCH_WIDTH'(1));
                laneInst  = headBundle.inst[laneSlot];
                lanePc    = headBundle.pc + SIZE_PC'({laneSlot, 2'b00});
                laneCtrl  = preDecode(laneInst);
                if (laneValid) begin
                    decPacket_o[i].valid    = 1'b1;
                    decPacket_o[i].pc       = lanePc;
                    decPacket_o[i].inst     = laneInst;
                    decPacket_o[i].seqNo    = seqNoReg + SIZE_SEQ'(i);
                    decPacket_o[i].ctiID    = ctiIDReg + ctrlCnt;
                    decPacket_o[i].ctrlType = laneCtrl;
                    if (laneCtrl != CTRL_NONE) begin
                        decPacket_o[i].predNPC = headBundle.predNPC[laneSlot];
                        decPacket_o[i].predDir = headBundle.predDir[laneSlot];
                        ctrlCnt = ctrlCnt + SIZE_CTI'(1);
                    end else begin
                        decPacket_o[i].predNPC = lanePc + SIZE_PC'(4);
                        decPacket_o[i].predDir = 1'b0;
                    end
                    laneCnt = laneCnt + SIZE_SEQ'(1);
                end
            end
            leftMask    = avail;
            slotPtrNext = lowestSlot(avail);
        end
    end

    assign advance = !stall_i && !flush_i && decPacket_o[0].valid;
    assign pop     = advance && (headBundle.exc || leftMask == '0);

    // seqNo is deliberately not rewound on flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slotPtr  <= '0;
            seqNoReg <= '0;
            ctiIDReg <= '0;
        end else if (flush_i) begin
            slotPtr  <= '0;
            ctiIDReg <= recoverCtiID_i;
        end else if (advance) begin
            slotPtr  <= pop ? '0 : slotPtrNext;
            seqNoReg <= seqNoReg + laneCnt;
            ctiIDReg <= ctiIDReg + ctrlCnt;
        end
    end

endmodule

// File: tb/tb_fetch_decode_packetizer.sv
// Scoreboard bench: the driver queues expected packets per accepted bundle,
// a negedge monitor numbers them and checks every emitted lane.
module tb_fetch_decode_packetizer;
    import fetch_decode_packetizer_pkg::*;

    logic                            clk = 1'b0;
    logic                            reset;
    logic                            flush_i;
    logic [SIZE_CTI-1:0]             recoverCtiID_i;
    logic                            fetchValid_i;
    logic                            fetchReady_o;
    logic [SIZE_PC-1:0]              fetchPC_i;
    logic [FETCH_WIDTH*32-1:0]       fetchInst_i;
    logic [FETCH_WIDTH-1:0]          fetchMask_i;
    logic [FETCH_WIDTH*SIZE_PC-1:0]  fetchPredNPC_i;
    logic [FETCH_WIDTH-1:0]          fetchPredDir_i;
    logic                            fetchExc_i;
    logic [EXCEPTION_CAUSE_LOG-1:0]  fetchExcCause_i;
    logic                            stall_i;
    decPkt [DEC_WIDTH-1:0]           decPacket_o;

    fetch_decode_packetizer dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .recoverCtiID_i(recoverCtiID_i),
        .fetchValid_i(fetchValid_i), .fetchReady_o(fetchReady_o), .fetchPC_i(fetchPC_i),
        .fetchInst_i(fetchInst_i), .fetchMask_i(fetchMask_i), .fetchPredNPC_i(fetchPredNPC_i),
        .fetchPredDir_i(fetchPredDir_i), .fetchExc_i(fetchExc_i), .fetchExcCause_i(fetchExcCause_i),
        .stall_i(stall_i), .decPacket_o(decPacket_o)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_ALU = 32'h0010_0093;
    localparam logic [31:0] I_BEQ = 32'h0020_8063;
    localparam logic [31:0] I_JAL = 32'h0080_00EF;
    localparam logic [31:0] I_RET = 32'h0000_8067;
    localparam logic [31:0] I_IND = 32'h0003_00E7;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        ctrlType_t   ctrl;
        logic [31:0] predNPC;
        logic        predDir;
        logic        exc;
        logic [3:0]  cause;
        int          bid;
    } expT;

    expT         q[$];
    int          expSeq = 0;
    int          expCti = 0;
    int          bidCtr = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] tInst [FETCH_WIDTH];
    logic [31:0] tNpc  [FETCH_WIDTH];
    logic        prevHold = 1'b0;
    decPkt [DEC_WIDTH-1:0] prevOut;
    logic        e1;

    function automatic ctrlType_t refCtrl(input logic [31:0] inst);
        if (inst[6:0] == 7'h6F) return CTRL_JUMP_DIRECT;
        if (inst[6:0] == 7'h67)
            return (inst[11:7] == 5'd0 && inst[19:15] == 5'd1) ? CTRL_RETURN : CTRL_JUMP_INDIRECT;
        if (inst[6:0] == 7'h63) return CTRL_BRANCH;
        return CTRL_NONE;
    endfunction

    function automatic logic [31:0] randInst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r[6:0] = 7'h6F;
            1: r[6:0] = 7'h67;
            2: begin r[6:0] = 7'h67; r[11:7] = 5'd0; r[19:15] = 5'd1; end
            3: r[6:0] = 7'h63;
            default: r[6:0] = 7'h13;
        endcase
        return r;
    endfunction

    function automatic int bundlesInQ();
        int n;
        n = 0;
        for (int k = 0; k < q.size(); k++)
            if (k == 0 || q[k].bid != q[k-1].bid) n++;
        return n;
    endfunction

    task automatic setBundle(input logic [31:0] pc, input logic [3:0] mask,
                             input logic exc, input logic [3:0] cause);
        fetchValid_i    = 1'b1;
        fetchPC_i       = pc;
        fetchMask_i     = mask;
        fetchExc_i      = exc;
        fetchExcCause_i = cause;
        for (int s = 0; s < FETCH_WIDTH; s++) begin
            fetchInst_i[s*32 +: 32]          = tInst[s];
            fetchPredNPC_i[s*SIZE_PC +: SIZE_PC] = tNpc[s];
        end
        fetchPredDir_i = 4'($urandom);
    endtask

    task automatic setInsts(input logic [31:0] i0, input logic [31:0] i1,
                            input logic [31:0] i2, input logic [31:0] i3);
        tInst[0] = i0; tInst[1] = i1; tInst[2] = i2; tInst[3] = i3;
        for (int s = 0; s < FETCH_WIDTH; s++) tNpc[s] = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic pushBundle();
        expT e;
        int first;
        e.bid = bidCtr;
        bidCtr++;
        if (fetchExc_i) begin
            first = 0;
            for (int s = FETCH_WIDTH - 1; s >= 0; s--) if (fetchMask_i[s]) first = s;
            e.pc = fetchPC_i + 32'(4 * first);
            e.inst = 32'h0000_0013; e.ctrl = CTRL_NONE; e.predNPC = 0; e.predDir = 0;
            e.exc = 1'b1; e.cause = fetchExcCause_i;
            q.push_back(e);
        end else begin
            for (int s = 0; s < FETCH_WIDTH; s++) begin
                if (fetchMask_i[s]) begin
                    e.pc   = fetchPC_i + 32'(4 * s);
                    e.inst = fetchInst_i[s*32 +: 32];
                    e.ctrl = refCtrl(e.inst);
                    e.predNPC = (e.ctrl != CTRL_NONE) ? fetchPredNPC_i[s*SIZE_PC +: SIZE_PC] : e.pc + 4;
                    e.predDir = (e.ctrl != CTRL_NONE) ? fetchPredDir_i[s] : 1'b0;
                    e.exc = 1'b0; e.cause = 0;
                    q.push_back(e);
                end
            end
        end
    endtask

    // Called at posedge+1; acts on the handshake at posedge+7, after the monitor
    task automatic step();
        #6;
        if (!reset && flush_i) begin
            q.delete();
            expCti = int'(recoverCtiID_i);
        end else if (!reset && fetchValid_i && fetchReady_o && (fetchMask_i != 0 || fetchExc_i))
            pushBundle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        fetchValid_i = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic checkReset(input string tag);
        total++;
        if (decPacket_o[0].valid !== 1'b0 || decPacket_o[1].valid !== 1'b0 || fetchReady_o !== 1'b1) begin
            bad++;
            $display("FAIL %s: valid=%b%b ready=%b, required valid=00 ready=1", tag,
                     decPacket_o[1].valid, decPacket_o[0].valid, fetchReady_o);
        end
    endtask

    task automatic checkLane(input int lane, input decPkt p, input expT e, input int seq, input int cti);
        logic ok;
        ok = p.valid && p.pc == e.pc && p.inst == e.inst && p.seqNo == SIZE_SEQ'(seq)
             && p.ctrlType == e.ctrl && p.exception == e.exc;
        if (e.ctrl != CTRL_NONE) ok = ok && (p.ctiID == SIZE_CTI'(cti));
        if (e.exc) ok = ok && (p.exceptionCause == e.cause);
        else       ok = ok && (p.predNPC == e.predNPC) && (p.predDir == e.predDir);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL lane%0d: got pc=%h inst=%h seq=%0d cti=%0d ctrl=%0d npc=%h dir=%b exc=%b cause=%0d; want pc=%h inst=%h seq=%0d cti=%0d ctrl=%0d npc=%h dir=%b exc=%b cause=%0d",
                     lane, p.pc, p.inst, p.seqNo, p.ctiID, p.ctrlType, p.predNPC, p.predDir, p.exception,
                     p.exceptionCause, e.pc, e.inst, seq % 256, cti % 16, e.ctrl, e.predNPC, e.predDir,
                     e.exc, e.cause);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prevHold = 1'b0;
        end else begin
            total++;
            if (fetchReady_o !== (bundlesInQ() < DEPTH)) begin
                bad++;
                $display("FAIL ready: got %b want %b", fetchReady_o, bundlesInQ() < DEPTH);
            end
            if (flush_i) begin
                total++;
                if (decPacket_o[0].valid || decPacket_o[1].valid) begin
                    bad++;
                    $display("FAIL flush_invalid: got valid=%b%b want 00", decPacket_o[1].valid, decPacket_o[0].valid);
                end
            end else begin
                if (prevHold) begin
                    total++;
                    if (decPacket_o !== prevOut) begin
                        bad++;
                        $display("FAIL stall_stable: got %h want %h", decPacket_o, prevOut);
                    end
                end
                if (q.size() == 0) begin
                    total++;
                    if (decPacket_o[0].valid || decPacket_o[1].valid) begin
                        bad++;
                        $display("FAIL unexpected: got valid=%b%b want 00 (pc=%h)",
                                 decPacket_o[1].valid, decPacket_o[0].valid, decPacket_o[0].pc);
                    end
                end else if (!decPacket_o[0].valid) begin
                    total++;
                    bad++;
                    $display("FAIL lane0_missing: got valid=0 want 1 (pc=%h)", q[0].pc);
                end else begin
                    checkLane(0, decPacket_o[0], q[0], expSeq, expCti);
                    e1 = q.size() > 1 && q[1].bid == q[0].bid && !q[0].exc;
                    total++;
                    if (decPacket_o[1].valid !== e1) begin
                        bad++;
                        $display("FAIL lane1_valid: got %b want %b", decPacket_o[1].valid, e1);
                    end else if (e1) begin
                        checkLane(1, decPacket_o[1], q[1], expSeq + 1,
                                  expCti + ((q[0].ctrl != CTRL_NONE) ? 1 : 0));
                    end
                    if (!stall_i) begin
                        for (int k = 0; k < (e1 ? 2 : 1); k++) begin
                            if (q[0].ctrl != CTRL_NONE) expCti = (expCti + 1) % 16;
                            expSeq = (expSeq + 1) % 256;
                            void'(q.pop_front());
                        end
                    end
                end
            end
            prevHold = stall_i && !flush_i && decPacket_o[0].valid;
            prevOut  = decPacket_o;
        end
    end

    initial begin
        reset = 1'b1; flush_i = 0; recoverCtiID_i = 0; fetchValid_i = 0; fetchPC_i = 0;
        fetchInst_i = 0; fetchMask_i = 0; fetchPredNPC_i = 0; fetchPredDir_i = 0;
        fetchExc_i = 0; fetchExcCause_i = 0; stall_i = 0;
        setInsts(I_ALU, I_ALU, I_ALU, I_ALU);
        @(posedge clk); #1;
        checkReset("reset_state");
        @(posedge clk); #1;
        reset = 1'b0;

        // full bundle, then sparse bundle
        setBundle(32'h1000, 4'b1111, 0, 0); step();
        idle(3);
        setBundle(32'h2000, 4'b1010, 0, 0); step();
        idle(2);

        // ctiID wrap: recover to 15, branch + jal in one cycle, then a return
        flush_i = 1; recoverCtiID_i = 4'd15; fetchValid_i = 0; step();
        flush_i = 0;
        setInsts(I_ALU, I_BEQ, I_JAL, I_ALU);
        setBundle(32'h3000, 4'b0110, 0, 0); step();
        idle(2);
        setInsts(I_RET, I_IND, I_ALU, I_ALU);
        setBundle(32'h3100, 4'b0011, 0, 0); step();
        idle(2);

        // stall mid-bundle for 3 cycles while fetch keeps offering
        setInsts(I_ALU, I_JAL, I_ALU, I_BEQ);
        setBundle(32'h4000, 4'b1111, 0, 0); step();
        setBundle(32'h5000, 4'b1111, 0, 0); step();
        stall_i = 1;
        setBundle(32'h6000, 4'b1011, 0, 0);
        step(); step(); step();
        stall_i = 0;
        for (int k = 0; k < 6; k++) step();
        idle(3);

        // fetch fault, followed immediately by a normal bundle
        setBundle(32'h7000, 4'b0110, 1, 4'd1); step();
        setInsts(I_ALU, I_ALU, I_ALU, I_ALU);
        setBundle(32'h8000, 4'b0001, 0, 0); step();
        setBundle(32'h9000, 4'b0000, 1, 4'd7); step();
        setBundle(32'h9100, 4'b0000, 0, 0); step();
        idle(3);

        // flush with two bundles buffered and one incoming, stall also high
        stall_i = 1;
        setBundle(32'hA000, 4'b1111, 0, 0); step();
        setBundle(32'hB000, 4'b1111, 0, 0); step();
        flush_i = 1; recoverCtiID_i = 4'd5;
        setBundle(32'hC000, 4'b1111, 0, 0); step();
        flush_i = 0; stall_i = 0;
        setInsts(I_JAL, I_BEQ, I_ALU, I_ALU);
        setBundle(32'hD000, 4'b0111, 0, 0); step();
        idle(3);

        // reset mid-bundle
        setInsts(I_ALU, I_ALU, I_ALU, I_ALU);
        setBundle(32'hE000, 4'b1111, 0, 0); step();
        fetchValid_i = 0; step();
        #2 reset = 1'b1;
        #1 checkReset("reset_mid_bundle");
        q.delete(); expSeq = 0; expCti = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        setBundle(32'hF000, 4'b1111, 0, 0); step();
        idle(3);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            setInsts(randInst(), randInst(), randInst(), randInst());
            if ($urandom_range(0, 3) != 0)
                setBundle({16'h0, 16'($urandom)} & 32'hFFFF_FFF0, 4'($urandom),
                          ($urandom_range(0, 7) == 0), 4'($urandom));
            else
                fetchValid_i = 0;
            stall_i = ($urandom_range(0, 3) == 0);
            flush_i = ($urandom_range(0, 24) == 0);
            recoverCtiID_i = 4'($urandom);
            step();
        end
        flush_i = 0; stall_i = 0;
        idle(12);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d packets outstanding want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
